// File: rtl/fp16_stream_accum.sv
// fp16_stream_accum: sums FP16 (1/5/10) words of each packet delimited by
// in_last, one word per multi-cycle align/add/normalize pass, and emits the
// packet sum together with a saturating element count.
// Optional build macro FP16_ACC_OVF_FLAG_EN adds o_out_ovf, a sticky
// per-packet flag for saturated or flushed-to-zero normalize results.
//
// Handshakes: a word moves on i_in_valid & o_in_ready, a sum moves on
// o_out_valid & i_out_ready. A valid side holds its payload stable until
// the transfer; ready never depends combinationally on valid.
module fp16_stream_accum #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [15:0]      i_in_data,
    input  logic             i_in_last,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [15:0]      o_out_data,
    output logic [CNT_W-1:0] o_out_count,
`ifdef FP16_ACC_OVF_FLAG_EN
    output logic             o_out_ovf,
`endif
    output logic [2:0]       o_dbg_state
);

    typedef enum logic [2:0] {
        S_RECV  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             w_in_ready_nxt;
    logic             w_out_valid_nxt;
    logic             w_xfer;
    logic             w_out_hs;

    logic [15:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_first;
    logic [15:0]      r_op;
    logic             r_last;

    // aligned operands
    logic [10:0]      r_fa;
    logic [10:0]      r_fb;
    logic             r_sa;
    logic             r_sb;
    logic [4:0]       r_exp;

    // raw sum
    logic [11:0]      r_sum;
    logic             r_sign;

`ifdef FP16_ACC_OVF_FLAG_EN
    logic             r_ovf;
    logic             w_norm_ovf;
`endif

    assign w_xfer   = i_in_valid & r_in_ready;
    assign w_out_hs = r_out_valid & i_out_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_RECV;
        else          r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RECV: begin
                if (w_xfer) begin
                    if (r_first) w_state_nxt = i_in_last ? S_OUT : S_RECV;
                    else         w_state_nxt = S_ALIGN;
                end
            end
            S_ALIGN: w_state_nxt = S_ADD;
            S_ADD:   w_state_nxt = S_NORM;
            S_NORM:  w_state_nxt = r_last ? S_OUT : S_RECV;
            S_OUT:   if (w_out_hs) w_state_nxt = S_RECV;
            default: w_state_nxt = S_RECV;
        endcase
    end

    // Output decode from the upcoming state so the handshake outputs are registered.
    always_comb begin
        w_in_ready_nxt  = (w_state_nxt == S_RECV);
        w_out_valid_nxt = (w_state_nxt == S_OUT);
    end

    // Registered handshake outputs; both low during and right after reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Align: zero operands (exp=0) carry a zero fraction; the smaller
    // exponent's fraction is right-shifted with truncation.
    // ------------------------------------------------------------------
    logic [4:0]  w_ea;
    logic [4:0]  w_eb;
    logic [10:0] w_fa;
    logic [10:0] w_fb;
    logic [4:0]  w_diff;
    logic [10:0] w_fa_al;
    logic [10:0] w_fb_al;
    logic [4:0]  w_exp_al;

    // Fraction alignment of accumulator and latched operand.
    always_comb begin
        w_ea     = r_acc[14:10];
        w_eb     = r_op[14:10];
        w_fa     = (w_ea == 5'd0) ? 11'd0 : {1'b1, r_acc[9:0]};
        w_fb     = (w_eb == 5'd0) ? 11'd0 : {1'b1, r_op[9:0]};
        w_diff   = 5'd0;
        w_fa_al  = w_fa;
        w_fb_al  = w_fb;
        w_exp_al = w_ea;
        if (w_ea >= w_eb) begin
            w_diff   = w_ea - w_eb;
            w_fb_al  = (w_diff >= 5'd11) ? 11'd0 : (w_fb >> w_diff);
            w_exp_al = w_ea;
        end else begin
            w_diff   = w_eb - w_ea;
            w_fa_al  = (w_diff >= 5'd11) ? 11'd0 : (w_fa >> w_diff);
            w_exp_al = w_eb;
        end
    end

    // ------------------------------------------------------------------
    // Add: sign-magnitude sum; an exact cancellation yields +0.
    // ------------------------------------------------------------------
    logic [11:0] w_sum;
    logic        w_sum_sign;

    // Signed-magnitude add/subtract of the aligned fractions.
    always_comb begin
        w_sum      = 12'd0;
        w_sum_sign = 1'b0;
        if (r_sa == r_sb) begin
            w_sum      = {1'b0, r_fa} + {1'b0, r_fb};
            w_sum_sign = r_sa;
        end else if (r_fa > r_fb) begin
            w_sum      = {1'b0, r_fa} - {1'b0, r_fb};
            w_sum_sign = r_sa;
        end else if (r_fb > r_fa) begin
            w_sum      = {1'b0, r_fb} - {1'b0, r_fa};
            w_sum_sign = r_sb;
        end
    end

    // ------------------------------------------------------------------
    // Normalize: carry shifts right once; otherwise left-shift the
    // leading one into bit 10. Underflow flushes to +0, overflow
    // saturates to the largest finite magnitude.
    // ------------------------------------------------------------------
    logic [3:0]        w_lz;
    logic              w_found;
    logic [9:0]        w_nman;
    logic signed [6:0] w_exp_s;
    logic signed [6:0] w_nexp;
    logic [15:0]       w_norm;
    logic              w_sat;
    logic              w_flush;

    // Leading-one detect, exponent adjust and range handling.
    always_comb begin
        w_lz    = 4'd0;
        w_found = 1'b0;
        for (int i = 10; i >= 0; i--) begin
            if (!w_found && r_sum[i]) begin
                w_lz    = 4'(10 - i);
                w_found = 1'b1;
            end
        end
        w_exp_s = $signed({2'b00, r_exp});
        if (r_sum[11]) begin
            w_nman = r_sum[10:1];
            w_nexp = w_exp_s + 7'sd1;
        end else begin
            w_nman = r_sum[9:0] << w_lz;
            w_nexp = w_exp_s - $signed({3'b000, w_lz});
        end
        w_sat   = 1'b0;
        w_flush = 1'b0;
        if (r_sum == 12'd0) begin
            w_norm = 16'h0000;
        end else if (w_nexp <= 7'sd0) begin
            w_norm  = 16'h0000;
            w_flush = 1'b1;
        end else if (w_nexp > 7'sd30) begin
            w_norm = {r_sign, 15'h7BFF};
            w_sat  = 1'b1;
        end else begin
            w_norm = {r_sign, w_nexp[4:0], w_nman};
        end
`ifdef FP16_ACC_OVF_FLAG_EN
        w_norm_ovf = w_sat | w_flush;
`endif
    end

    // ------------------------------------------------------------------
    // Datapath registers, advanced by the current state.
    // ------------------------------------------------------------------

    // Accumulator, counter, pipeline latches and first-word bookkeeping.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc   <= 16'h0000;
            r_cnt   <= '0;
            r_first <= 1'b1;
            r_op    <= 16'h0000;
            r_last  <= 1'b0;
            r_fa    <= 11'd0;
            r_fb    <= 11'd0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_exp   <= 5'd0;
            r_sum   <= 12'd0;
            r_sign  <= 1'b0;
`ifdef FP16_ACC_OVF_FLAG_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_RECV: begin
                    if (w_xfer) begin
                        if (r_first) begin
                            r_acc   <= (i_in_data[14:10] == 5'd0) ? 16'h0000 : i_in_data;
                            r_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
                            r_first <= 1'b0;
                        end else begin
                            r_op   <= i_in_data;
                            r_last <= i_in_last;
                            if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_ALIGN: begin
                    r_fa  <= w_fa_al;
                    r_fb  <= w_fb_al;
                    r_sa  <= r_acc[15];
                    r_sb  <= r_op[15];
                    r_exp <= w_exp_al;
                end
                S_ADD: begin
                    r_sum  <= w_sum;
                    r_sign <= w_sum_sign;
                end
                S_NORM: begin
                    r_acc <= w_norm;
`ifdef FP16_ACC_OVF_FLAG_EN
                    if (w_norm_ovf) r_ovf <= 1'b1;
`endif
                end
                S_OUT: begin
                    if (w_out_hs) begin
                        r_first <= 1'b1;
`ifdef FP16_ACC_OVF_FLAG_EN
                        r_ovf   <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_valid ? r_acc : 16'h0000;
    assign o_out_count = r_out_valid ? r_cnt : '0;
`ifdef FP16_ACC_OVF_FLAG_EN
    assign o_out_ovf   = r_out_valid & r_ovf;
`endif
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fp16_stream_accum.sv
// Bench for fp16_stream_accum: directed packets from the test plan plus
// random packets scored against an integer-arithmetic reference model.
module tb_fp16_stream_accum;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_data = 16'h0000;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic [2:0]       dbg_state;
`ifdef FP16_ACC_OVF_FLAG_EN
    logic             out_ovf;
`endif

    int checks = 0;
    int failures = 0;

    // scoreboard
    logic [15:0]      exp_q[$];
    logic [CNT_W-1:0] cnt_q[$];
    logic             ovf_q[$];
    logic [15:0]      pkt[$];

    fp16_stream_accum #(.CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .i_in_last   (in_last),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_count (out_count),
`ifdef FP16_ACC_OVF_FLAG_EN
        .o_out_ovf   (out_ovf),
`endif
        .o_dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: one FP16 addition from the arithmetic rules, returns {ovf, sum}.
    function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, fa, fb, e, va, vb, t, mag;
        logic sgn;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        fa = (ea == 0) ? 0 : 1024 + int'(a[9:0]);
        fb = (eb == 0) ? 0 : 1024 + int'(b[9:0]);
        e  = (ea > eb) ? ea : eb;
        fa = (e - ea >= 11) ? 0 : (fa >> (e - ea));
        fb = (e - eb >= 11) ? 0 : (fb >> (e - eb));
        va = a[15] ? -fa : fa;
        vb = b[15] ? -fb : fb;
        t  = va + vb;
        sgn = (t < 0);
        mag = sgn ? -t : t;
        if (mag == 0) return 17'h0_0000;
        while (mag >= 2048) begin mag = mag / 2; e = e + 1; end
        while (mag < 1024)  begin mag = mag * 2; e = e - 1; end
        if (e <= 0) return {1'b1, 16'h0000};
        if (e > 30) return {1'b1, sgn, 15'h7BFF};
        return {1'b0, sgn, 5'(e), 10'(mag - 1024)};
    endfunction

    // Send one word; reports how many cycles it waited for in_ready.
    task automatic send_word(input logic [15:0] d, input logic last, output int waited);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        waited   = 0;
        while (!in_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 16'($urandom_range(0, 16'hFFFF));
        in_last  = 1'($urandom_range(0, 1));
    endtask

    // Send pkt[]; scoreboard gets either the model result or a literal expectation.
    task automatic send_pkt(input logic use_model, input logic [15:0] lit_data, input logic lit_ovf);
        int n, w;
        logic [16:0] r;
        logic [15:0] acc;
        logic ovf;
        n = pkt.size();
        acc = (pkt[0][14:10] == 5'd0) ? 16'h0000 : pkt[0];
        ovf = 1'b0;
        for (int i = 1; i < n; i++) begin
            r = ref_add(acc, pkt[i]);
            acc = r[15:0];
            ovf = ovf | r[16];
        end
        exp_q.push_back(use_model ? acc : lit_data);
        ovf_q.push_back(use_model ? ovf : lit_ovf);
        cnt_q.push_back((n > 255) ? CNT_W'(255) : CNT_W'(n));
        for (int i = 0; i < n; i++) begin
            send_word(pkt[i], (i == n - 1), w);
            if (i == 1) chk("ready_after_first", 32'(w), 32'd0);
            if (i >= 2) chk("ready_gap", 32'(w), 32'd3);
        end
    endtask

    // Wait for the sum, check latency, optionally stall, then handshake.
    task automatic recv_pkt(input int exp_lat, input int hold);
        int waited;
        logic [15:0] ed;
        logic [CNT_W-1:0] ec;
        logic eo;
        waited = 0;
        while (!out_valid && waited < 20) begin
            tick();
            waited++;
        end
        chk("out_valid", 32'(out_valid), 32'd1);
        if (exp_lat > 0) chk("latency", 32'(waited + 1), 32'(exp_lat));
        ed = exp_q.pop_front();
        ec = cnt_q.pop_front();
        eo = ovf_q.pop_front();
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(ed));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        chk("out_data", 32'(out_data), 32'(ed));
        chk("out_count", 32'(out_count), 32'(ec));
`ifdef FP16_ACC_OVF_FLAG_EN
        chk("out_ovf", 32'(out_ovf), 32'(eo));
`else
        if (eo === 1'bx) chk("ovf_model", 32'(eo), 32'd0);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n, w;

        // reset
        rst_n = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b0;
        tick();
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // directed packets
        pkt = '{16'h3C00, 16'h3C00};
        send_pkt(1'b0, 16'h4000, 1'b0);
        recv_pkt(4, 0);

        pkt = '{16'h3C00, 16'h4000, 16'h3C00};
        send_pkt(1'b0, 16'h4400, 1'b0);
        recv_pkt(4, 0);

        pkt = '{16'h3C00, 16'hBC00};
        send_pkt(1'b0, 16'h0000, 1'b0);
        recv_pkt(4, 0);

        pkt = '{16'h4500};
        send_pkt(1'b0, 16'h4500, 1'b0);
        recv_pkt(1, 0);

        pkt = '{16'h7BFF, 16'h7BFF};
        send_pkt(1'b0, 16'h7BFF, 1'b1);
        recv_pkt(4, 0);

        // out_ready held low for 5 cycles
        pkt = '{16'h3C00, 16'h3800};
        send_pkt(1'b0, 16'h3E00, 1'b0);
        recv_pkt(4, 5);

        pkt = '{16'h0400, 16'h0000, 16'h8000};
        send_pkt(1'b0, 16'h0400, 1'b0);
        recv_pkt(4, 0);

        // reset while the second word is in the add stage
        send_word(16'h3C00, 1'b0, w);
        send_word(16'h3C00, 1'b1, w);
        tick();
        chk("in_add_state", 32'(dbg_state), 32'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_out_count", 32'(out_count), 32'd0);
        chk("midrst_state", 32'(dbg_state), 32'd0);

        pkt = '{16'h4000};
        send_pkt(1'b0, 16'h4000, 1'b0);
        recv_pkt(1, 0);

        // random packets against the reference model
        for (int p = 0; p < 30; p++) begin
            n = $urandom_range(1, 5);
            pkt.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0) pkt.push_back(16'($urandom_range(0, 1) << 15));
                else pkt.push_back(16'($urandom_range(0, 16'hFFFF)));
            end
            send_pkt(1'b1, 16'h0000, 1'b0);
            recv_pkt((n == 1) ? 1 : 4, $urandom_range(0, 3));
        end

        // count saturation on a long packet
        pkt.delete();
        for (int i = 0; i < 260; i++) pkt.push_back(16'($urandom_range(16'h3000, 16'h4400)));
        send_pkt(1'b1, 16'h0000, 1'b0);
        recv_pkt(4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp16_stream_accum.md
Name: fp16_stream_accum

Overview:
- Sequential accumulator for half-precision (1/5/10) values, placed upstream of the result path.
- Consumes a valid/ready stream of FP16 words grouped into packets by `in_last`, and sums each packet.
- Emits one FP16 sum per packet on a valid/ready output, together with the element count.
- Addition is multi-cycle: align, add, normalize. The arithmetic rules are stated in full below.

Parameters:
- CNT_W, 8, width of the per-packet element counter and of `out_count`.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept an input word
- in_data  in  16  FP16 operand {sign, exp[4:0], man[9:0]}
- in_last  in  1  marks the final word of a packet
- out_valid  out  1  packet sum valid
- out_ready  in  1  downstream accepts the sum
- out_data  out  16  FP16 packet sum
- out_count  out  CNT_W  number of words in the packet; saturates at 2^CNT_W-1

Behaviour:
- Reset: synchronous, sampled on the clk edge while rst_n=0. All outputs are 0 during and after reset: in_ready=0, out_valid=0, out_data=0, out_count=0. The accumulator and counter clear, the first-word flag sets, and state goes to S_RECV. Reset overrides any state, including mid-add or while out_valid is held.
- States: S_RECV, S_ALIGN, S_ADD, S_NORM, S_OUT.
- in_ready = 1 only in S_RECV, registered. A transfer occurs when in_valid & in_ready.
- S_RECV, transfer with the first-word flag set:
  - acc <= in_data, count <= 1, flag cleared.
  - Next state: S_OUT if in_last, else stay in S_RECV.
  - Exception: an operand with exp=0 loads as 0x0000.
- S_RECV, transfer with the flag clear:
  - Latch the operand and in_last; go to S_ALIGN.
  - Count increments, saturating.
- S_ALIGN:
  - Each operand has fraction {1, man} (11 bits). An exp=0 operand is an exact zero (fraction 0).
  - The smaller-exponent fraction is shifted right by the exponent difference; bits shifted out are truncated. A difference >= 11 gives 0.
  - Working exponent = the larger exponent.
- S_ADD:
  - Same signs: 12-bit sum, sign kept.
  - Different signs: magnitude difference; sign = sign of the larger magnitude; result +0 on an exact tie.
- S_NORM:
  - Carry (bit 11 set): shift right 1, exponent +1.
  - Otherwise: leading-one detect, then left-shift until bit 10 = 1, decrementing the exponent per bit.
  - Result forced to 0x0000 if: the fraction is 0, or the exponent <= 0.
  - Exponent > 30: saturate to {sign, 0x7BFF}.
  - acc <= result. Next state: S_OUT if the latched last, else S_RECV.
- S_OUT:
  - out_valid=1; out_data=acc and out_count=count, held stable until out_ready.
  - On out_valid & out_ready: out_valid drops next cycle, the flag sets, and state returns to S_RECV.
- Latency:
  - Single-word packet: out_valid is asserted 1 cycle after the transfer.
  - Multi-word packet: each non-first word takes 4 cycles (RECV + 3). out_valid is asserted 1 cycle after S_NORM of the last word.
- in_data is ignored when in_valid=0. in_last on a non-transferring cycle is ignored.
- Count saturation does not affect the sum.
- out_ready held high outside S_OUT has no effect.

Optional Feature:
- Macro FP16_ACC_OVF_FLAG_EN.
- Defined: adds output port `out_ovf` (1 bit). It is a sticky per-packet flag, set when any S_NORM of the packet saturates or flushes a nonzero exact result to zero. It is valid alongside out_valid and clears on the output handshake and on reset.
- Undefined: no port and no flag logic; the arithmetic is identical.

Test Plan:
- Packet {0x3C00, 0x3C00 last} -> out_data 0x4000, out_count 2, out_valid 4 cycles after the second transfer.
- Packet {0x3C00, 0x4000, 0x3C00 last} (1+2+1) -> 0x4400; in_ready low for 3 cycles after each non-first word.
- Packet {0x3C00, 0xBC00 last} -> 0x0000. Packet {0x4500 last} -> 0x4500, count 1, out_valid the next cycle.
- Packet {0x7BFF, 0x7BFF last} -> 0x7BFF; out_ovf=1 when FP16_ACC_OVF_FLAG_EN is defined.
- Hold out_ready=0 for 5 cycles in S_OUT -> out_data/out_count stable, in_ready=0; the handshake then returns to S_RECV with a fresh packet.
- Assert rst_n=0 for 1 cycle during S_ADD -> all outputs 0. The next packet {0x4000 last} -> 0x4000, count 1.
